pipe_src: RTL and testbench

Valid/ready stream source that drives the input side of a pipe stage or any other valid/ready consumer. It emits programmable-length bursts of 32-bit data words. The data comes from a Galois LFSR or an incrementing counter, with an optional idle gap between beats. It holds `data_o` stable under backpressure and reports progress and completion. It is used as the traffic generator in front of pipe stages in block-level and integration benches, and as an on-chip pattern source.

---
 rtl/pipe_src.sv | 136 +++++++++++++
 tb/tb_pipe_src.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_src.sv
// rtl/pipe_src.sv - valid/ready burst source with LFSR or counter pattern and idle gaps
module pipe_src #(
    parameter int              DW    = 32,
    parameter int              CNT_W = 16,
    parameter logic [DW-1:0]   SEED  = 32'hA5A5A5A5,
    parameter logic [DW-1:0]   POLY  = 32'h80200003
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic [7:0]       gap,
    input  logic             mode,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [DW-1:0]    data_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] beat_cnt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [DW-1:0]    data_q, data_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [7:0]       gap_q, gap_d;
    logic [7:0]       gap_cnt_q, gap_cnt_d;
    logic             mode_q, mode_d;
    logic [CNT_W-1:0] beat_q, beat_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] beat_inc;
    logic             handshake;

    // Pattern step: Galois LFSR shift-right with tap mask, or plain increment.
    function automatic logic [DW-1:0] next_word(input logic m, input logic [DW-1:0] d);
        logic [DW-1:0] r;
        if (m) begin
            r = d + DW'(1);
        end else begin
            r = (d >> 1) ^ (d[0] ? POLY : '0);
        end
        return r;
    endfunction

    assign handshake  = (state_q == SEND) && ready_i;
    assign beat_inc   = beat_q + {{(CNT_W-1){1'b0}}, 1'b1};

    // Outputs are pure functions of registered state so valid_o never depends on ready_i.
    assign valid_o    = (state_q == SEND);
    assign busy_o     = (state_q != IDLE);
    assign data_o     = data_q;
    assign done_o     = done_q;
    assign beat_cnt_o = beat_q;

    // State and datapath registers; reset is asynchronous and asserted when rst_n is high.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q   <= IDLE;
            data_q    <= '0;
            len_q     <= '0;
            gap_q     <= '0;
            gap_cnt_q <= '0;
            mode_q    <= 1'b0;
            beat_q    <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            len_q     <= len_d;
            gap_q     <= gap_d;
            gap_cnt_q <= gap_cnt_d;
            mode_q    <= mode_d;
            beat_q    <= beat_d;
            done_q    <= done_d;
        end
    end

    // Next-state logic: burst setup in IDLE, beat accounting in SEND, gap countdown in GAP.
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        len_d     = len_q;
        gap_d     = gap_q;
        gap_cnt_d = gap_cnt_q;
        mode_d    = mode_q;
        beat_d    = beat_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    beat_d = '0;
                    if (len != '0) begin
                        len_d   = len;
                        gap_d   = gap;
                        mode_d  = mode;
                        data_d  = mode ? '0 : SEED;
                        state_d = SEND;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            SEND: begin
                if (handshake) begin
                    beat_d = beat_inc;
                    if (beat_inc == len_q) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        data_d = next_word(mode_q, data_q);
                        if (gap_q != 8'd0) begin
                            gap_cnt_d = gap_q;
                            state_d   = GAP;
                        end
                    end
                end
            end
            GAP: begin
                gap_cnt_d = gap_cnt_q - 8'd1;
                if (gap_cnt_q == 8'd1) begin
                    state_d = SEND;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pipe_src.sv
// tb/tb_pipe_src.sv - scoreboard bench for pipe_src
module tb_pipe_src;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] len;
    logic [7:0]  gap;
    logic        mode;
    logic        ready_i;
    logic        valid_o;
    logic [31:0] data_o;
    logic        busy_o;
    logic        done_o;
    logic [15:0] beat_cnt_o;

    int          n_cmp;
    int          n_err;
    logic [31:0] exp_q[$];

    pipe_src dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .len        (len),
        .gap        (gap),
        .mode       (mode),
        .ready_i    (ready_i),
        .valid_o    (valid_o),
        .data_o     (data_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .beat_cnt_o (beat_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected word number idx of a burst, computed from the pattern definition.
    function automatic logic [31:0] model_word(input logic m, input int idx);
        logic [31:0] w;
        w = m ? 32'h0 : 32'hA5A5A5A5;
        for (int i = 0; i < idx; i++) begin
            if (m) w = w + 32'h1;
            else   w = {1'b0, w[31:1]} ^ (w[0] ? 32'h80200003 : 32'h0);
        end
        return w;
    endfunction

    // Scoreboard: every handshake pops and compares one expected word.
    always @(negedge clk) begin
        if (!rst_n && valid_o && ready_i) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL beat_unexpected: got data %h, expected no beat", data_o);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (data_o !== e) begin
                    n_err++;
                    $display("FAIL beat_data: got %h expected %h", data_o, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_burst(input int l, input int g, input logic m, input int poke);
        int k;
        int budget;
        for (int i = 0; i < l; i++) exp_q.push_back(model_word(m, i));
        len = 16'(l); gap = 8'(g); mode = m; ready_i = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        k = 0;
        budget = l * (g + 1) + 10;
        while (done_o !== 1'b1 && k < budget) begin
            n_cmp++;
            if (valid_o !== ((k % (g + 1)) == 0)) begin
                n_err++;
                $display("FAIL valid_pattern: cycle %0d got %b expected %b", k, valid_o, ((k % (g + 1)) == 0));
            end
            n_cmp++;
            if (busy_o !== 1'b1) begin
                n_err++;
                $display("FAIL busy_in_burst: cycle %0d got %b expected 1", k, busy_o);
            end
            if (k == poke) begin
                start = 1'b1; len = 16'd2; gap = 8'd5; mode = ~m;
            end else begin
                start = 1'b0;
            end
            tick();
            k++;
        end
        start = 1'b0;
        n_cmp++;
        if (done_o !== 1'b1) begin
            n_err++;
            $display("FAIL done_timeout: got done %b after %0d cycles, expected 1", done_o, k);
        end
        n_cmp++;
        if (k != l + (l - 1) * g) begin
            n_err++;
            $display("FAIL burst_cycles: got %0d expected %0d", k, l + (l - 1) * g);
        end
        n_cmp++;
        if (beat_cnt_o !== 16'(l)) begin
            n_err++;
            $display("FAIL beat_cnt: got %0d expected %0d", beat_cnt_o, l);
        end
        n_cmp++;
        if (busy_o !== 1'b0 || valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL idle_after_done: got busy %b valid %b expected 0 0", busy_o, valid_o);
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL words_left: got %0d undelivered expected 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        n_cmp++;
        if (valid_o !== 1'b0 || data_o !== 32'h0 || busy_o !== 1'b0 || done_o !== 1'b0 || beat_cnt_o !== 16'h0) begin
            n_err++;
            $display("FAIL reset_values: got v%b d%h b%b dn%b c%0d expected all 0", valid_o, data_o, busy_o, done_o, beat_cnt_o);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if (valid_o !== 1'b0) begin
                n_err++;
                $display("FAIL reset_idle_valid: got %b expected 0", valid_o);
            end
        end
    endtask

    task automatic test_single();
        run_burst(1, 0, 1'b0, -1);
        tick();
        n_cmp++;
        if (done_o !== 1'b0) begin
            n_err++;
            $display("FAIL done_width: got %b expected 0", done_o);
        end
        n_cmp++;
        if (beat_cnt_o !== 16'd1) begin
            n_err++;
            $display("FAIL beat_cnt_hold: got %0d expected 1", beat_cnt_o);
        end
    endtask

    task automatic test_back_to_back();
        run_burst(4, 0, 1'b0, -1);
        run_burst(4, 0, 1'b1, -1);
    endtask

    task automatic test_backpressure();
        int k;
        for (int i = 0; i < 3; i++) exp_q.push_back(model_word(1'b1, i));
        len = 16'd3; gap = 8'd0; mode = 1'b1; ready_i = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (valid_o !== 1'b1 || data_o !== 32'h0) begin
                n_err++;
                $display("FAIL bp_hold: got valid %b data %h expected 1 00000000", valid_o, data_o);
            end
            tick();
        end
        ready_i = 1'b1;
        k = 0;
        while (done_o !== 1'b1 && k < 10) begin
            tick();
            k++;
        end
        n_cmp++;
        if (done_o !== 1'b1 || beat_cnt_o !== 16'd3) begin
            n_err++;
            $display("FAIL bp_done: got done %b cnt %0d expected 1 3", done_o, beat_cnt_o);
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL bp_words_left: got %0d expected 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_gap();
        run_burst(3, 2, 1'b1, -1);
        run_burst(4, 1, 1'b0, -1);
    endtask

    task automatic test_len_zero();
        tick();
        len = 16'd0; gap = 8'd0; mode = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++;
        if (done_o !== 1'b1 || valid_o !== 1'b0 || busy_o !== 1'b0 || beat_cnt_o !== 16'd0) begin
            n_err++;
            $display("FAIL len0_done: got done %b valid %b busy %b cnt %0d expected 1 0 0 0", done_o, valid_o, busy_o, beat_cnt_o);
        end
        tick();
        n_cmp++;
        if (done_o !== 1'b0 || valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL len0_after: got done %b valid %b expected 0 0", done_o, valid_o);
        end
    endtask

    task automatic test_start_ignored();
        run_burst(6, 0, 1'b1, 2);
        run_burst(3, 2, 1'b0, 1);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 8; i++) exp_q.push_back(model_word(1'b1, i));
        len = 16'd8; gap = 8'd0; mode = 1'b1; ready_i = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (beat_cnt_o !== 16'd2 || valid_o !== 1'b1) begin
            n_err++;
            $display("FAIL mid_progress: got cnt %0d valid %b expected 2 1", beat_cnt_o, valid_o);
        end
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (valid_o !== 1'b0 || busy_o !== 1'b0 || data_o !== 32'h0 || beat_cnt_o !== 16'h0 || done_o !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: got v%b b%b d%h c%0d dn%b expected all 0", valid_o, busy_o, data_o, beat_cnt_o, done_o);
        end
        tick();
        rst_n = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if (done_o !== 1'b0 || valid_o !== 1'b0) begin
                n_err++;
                $display("FAIL post_reset_quiet: got done %b valid %b expected 0 0", done_o, valid_o);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b1;
        start = 1'b0;
        len = 16'd0;
        gap = 8'd0;
        mode = 1'b0;
        ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_gap();
        test_len_zero();
        test_start_ignored();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
